// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, field widths and state encoding for the fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned INSN_W   = 32;
  localparam int unsigned TARGET_W = 27;
  localparam int unsigned IMM_W    = 17;

  localparam logic [OPCODE_W-1:0] OP_J   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_BNE = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_JAL = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_JR  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_BLT = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_BEX = 5'b10110;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  // Sign-extend the N field to a full data word.
  function automatic logic [INSN_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(INSN_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_sequencer_branch_target.sv
// Redirect decision and target selection for the instruction in execute.
module branch_target
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 12
) (
  input  logic                ex_j_i,
  input  logic                ex_jal_i,
  input  logic                ex_jr_i,
  input  logic                ex_bne_i,
  input  logic                ex_blt_i,
  input  logic                ex_bex_i,
  input  logic                ex_neq_i,
  input  logic                ex_lt_i,
  input  logic                ex_rstatus_nz_i,
  input  logic [PC_W-1:0]     ex_pc_i,
  input  logic [TARGET_W-1:0] ex_target_i,
  input  logic [IMM_W-1:0]    ex_imm_i,
  input  logic [INSN_W-1:0]   ex_rd_val_i,
  output logic                taken_o,
  output logic [PC_W-1:0]     target_o,
  output logic [PC_W-1:0]     link_pc_o
);

  logic [INSN_W-1:0] imm_ext;
  logic [PC_W-1:0]   seq_pc;
  logic [PC_W-1:0]   br_target;
  logic              bex_taken;
  logic              unused_hi;

  // Address bits above the PC width are ignored by design.
  assign unused_hi = ^{ex_target_i[TARGET_W-1:PC_W], ex_rd_val_i[INSN_W-1:PC_W],
                       imm_ext[INSN_W-1:PC_W]};

  // Taken condition and prioritised target: jr > bex > j/jal > bne > blt.
  always_comb begin
    imm_ext   = sext_imm(ex_imm_i);
    seq_pc    = ex_pc_i + PC_W'(1);
    br_target = seq_pc + imm_ext[PC_W-1:0];
    bex_taken = ex_bex_i & ex_rstatus_nz_i;
    taken_o   = ex_jr_i | ex_j_i | ex_jal_i | bex_taken
              | (ex_bne_i & ex_neq_i) | (ex_blt_i & ex_lt_i);
    target_o  = br_target;
    if (ex_jr_i) begin
      target_o = ex_rd_val_i[PC_W-1:0];
    end else if (bex_taken) begin
      target_o = ex_target_i[PC_W-1:0];
    end else if (ex_j_i | ex_jal_i) begin
      target_o = ex_target_i[PC_W-1:0];
    end
    link_pc_o = seq_pc;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: drives synchronous IMEM, feeds decode, handles redirects.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = 12
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSN_W-1:0]   imem_q,
  input  logic                stall,
  input  logic                ex_j,
  input  logic                ex_jal,
  input  logic                ex_jr,
  input  logic                ex_bne,
  input  logic                ex_blt,
  input  logic                ex_bex,
  input  logic                ex_neq,
  input  logic                ex_lt,
  input  logic                ex_rstatus_nz,
  input  logic [PC_W-1:0]     ex_pc,
  input  logic [TARGET_W-1:0] ex_target,
  input  logic [IMM_W-1:0]    ex_imm,
  input  logic [INSN_W-1:0]   ex_rd_val,
  output logic [INSN_W-1:0]   fd_insn,
  output logic [PC_W-1:0]     fd_pc,
  output logic                fd_valid,
  output logic                flush,
  output logic [PC_W-1:0]     link_pc
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  // Address presented last cycle, i.e. the one whose word is on imem_q.
  logic [PC_W-1:0]   prev_q, prev_d;
  logic [INSN_W-1:0] fd_insn_q, fd_insn_d;
  logic [PC_W-1:0]   fd_pc_q, fd_pc_d;
  logic              fd_valid_q, fd_valid_d;
  // Word for prev_q captured at the start of a stall; the held address
  // overwrites imem_q during the stall, so this word would otherwise be lost.
  logic              hold_valid_q, hold_valid_d;
  logic [INSN_W-1:0] hold_insn_q, hold_insn_d;

  logic              taken;
  logic [PC_W-1:0]   target;

  branch_target #(.PC_W(PC_W)) u_branch_target (
    .ex_j_i          (ex_j),
    .ex_jal_i        (ex_jal),
    .ex_jr_i         (ex_jr),
    .ex_bne_i        (ex_bne),
    .ex_blt_i        (ex_blt),
    .ex_bex_i        (ex_bex),
    .ex_neq_i        (ex_neq),
    .ex_lt_i         (ex_lt),
    .ex_rstatus_nz_i (ex_rstatus_nz),
    .ex_pc_i         (ex_pc),
    .ex_target_i     (ex_target),
    .ex_imm_i        (ex_imm),
    .ex_rd_val_i     (ex_rd_val),
    .taken_o         (taken),
    .target_o        (target),
    .link_pc_o       (link_pc)
  );

  assign imem_addr = pc_q;
  assign fd_insn   = fd_insn_q;
  assign fd_pc     = fd_pc_q;
  assign fd_valid  = fd_valid_q;
  assign flush     = taken;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_PRIME;
      pc_q         <= '0;
      prev_q       <= '0;
      fd_insn_q    <= '0;
      fd_pc_q      <= '0;
      fd_valid_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_insn_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      prev_q       <= prev_d;
      fd_insn_q    <= fd_insn_d;
      fd_pc_q      <= fd_pc_d;
      fd_valid_q   <= fd_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_insn_q  <= hold_insn_d;
    end
  end

  // Next-state logic: redirect beats stall, stall freezes everything visible.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    prev_d       = prev_q;
    fd_insn_d    = fd_insn_q;
    fd_pc_d      = fd_pc_q;
    fd_valid_d   = fd_valid_q;
    hold_valid_d = hold_valid_q;
    hold_insn_d  = hold_insn_q;

    if (taken) begin
      state_d      = ST_SQUASH;
      pc_d         = target;
      prev_d       = pc_q;
      fd_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
    end else if (stall) begin
      if (state_q == ST_RUN && !hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_insn_d  = imem_q;
      end
    end else begin
      case (state_q)
        ST_PRIME: begin
          state_d    = ST_RUN;
          pc_d       = pc_q + PC_W'(1);
          prev_d     = pc_q;
          fd_valid_d = 1'b0;
        end
        ST_RUN: begin
          fd_insn_d    = hold_valid_q ? hold_insn_q : imem_q;
          fd_pc_d      = prev_q;
          fd_valid_d   = 1'b1;
          pc_d         = pc_q + PC_W'(1);
          prev_d       = pc_q;
          hold_valid_d = 1'b0;
        end
        ST_SQUASH: begin
          state_d      = ST_RUN;
          fd_valid_d   = 1'b0;
          pc_d         = pc_q + PC_W'(1);
          prev_d       = pc_q;
          hold_valid_d = 1'b0;
        end
        default: begin
          state_d    = ST_PRIME;
          fd_valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: program-order stream model plus directed cases.
module tb_fetch_sequencer;

  localparam int unsigned PC_W = 12;

  logic             clock;
  logic             reset;
  logic [PC_W-1:0]  imem_addr;
  logic [31:0]      imem_q;
  logic             stall;
  logic             ex_j, ex_jal, ex_jr, ex_bne, ex_blt, ex_bex;
  logic             ex_neq, ex_lt, ex_rstatus_nz;
  logic [PC_W-1:0]  ex_pc;
  logic [26:0]      ex_target;
  logic [16:0]      ex_imm;
  logic [31:0]      ex_rd_val;
  logic [31:0]      fd_insn;
  logic [PC_W-1:0]  fd_pc;
  logic             fd_valid;
  logic             flush;
  logic [PC_W-1:0]  link_pc;

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_q        (imem_q),
    .stall         (stall),
    .ex_j          (ex_j),
    .ex_jal        (ex_jal),
    .ex_jr         (ex_jr),
    .ex_bne        (ex_bne),
    .ex_blt        (ex_blt),
    .ex_bex        (ex_bex),
    .ex_neq        (ex_neq),
    .ex_lt         (ex_lt),
    .ex_rstatus_nz (ex_rstatus_nz),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_imm        (ex_imm),
    .ex_rd_val     (ex_rd_val),
    .fd_insn       (fd_insn),
    .fd_pc         (fd_pc),
    .fd_valid      (fd_valid),
    .flush         (flush),
    .link_pc       (link_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous IMEM whose word at each address is the address itself.
  always @(posedge clock) imem_q <= {20'd0, imem_addr};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: expected fetch address, mode, and next address in program order.
  localparam int M_PRIME  = 0;
  localparam int M_RUN    = 1;
  localparam int M_SQUASH = 2;
  int              m_mode;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_next;
  logic [PC_W-1:0] m_fd_pc;
  logic            m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_redirect(output bit tk, output logic [PC_W-1:0] tg);
    tk = ex_jr || ex_j || ex_jal || (ex_bex && ex_rstatus_nz)
      || (ex_bne && ex_neq) || (ex_blt && ex_lt);
    if (ex_jr)
      tg = ex_rd_val[PC_W-1:0];
    else if ((ex_bex && ex_rstatus_nz) || ex_j || ex_jal)
      tg = ex_target[PC_W-1:0];
    else
      tg = ex_pc + 12'd1 + ex_imm[PC_W-1:0];
  endtask

  task automatic model_step();
    bit tk;
    logic [PC_W-1:0] tg;
    model_redirect(tk, tg);
    if (reset) begin
      m_mode = M_PRIME; m_pc = '0; m_next = '0; m_fd_pc = '0; m_valid = 1'b0;
    end else if (tk) begin
      m_mode = M_SQUASH; m_pc = tg; m_next = tg; m_valid = 1'b0;
    end else if (!stall) begin
      if (m_mode == M_RUN) begin
        m_fd_pc = m_next;
        m_next  = m_next + 12'd1;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      m_mode = M_RUN;
      m_pc   = m_pc + 12'd1;
    end
  endtask

  task automatic compare();
    bit tk;
    logic [PC_W-1:0] tg;
    if (!chk_en) return;
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("fd_valid", 32'(fd_valid), 32'(m_valid));
    if (m_valid) begin
      chk("fd_pc", 32'(fd_pc), 32'(m_fd_pc));
      chk("fd_insn", fd_insn, 32'(m_fd_pc));
    end
    if (!reset) begin
      model_redirect(tk, tg);
      chk("flush", 32'(flush), 32'(tk));
      chk("link_pc", 32'(link_pc), 32'(ex_pc + 12'd1));
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic quiet();
    stall = 0; ex_j = 0; ex_jal = 0; ex_jr = 0; ex_bne = 0; ex_blt = 0; ex_bex = 0;
    ex_neq = 0; ex_lt = 0; ex_rstatus_nz = 0;
    ex_pc = '0; ex_target = '0; ex_imm = '0; ex_rd_val = '0;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_fd_valid", 32'(fd_valid), 32'd0);
    chk("rst_fd_pc", 32'(fd_pc), 32'd0);
    chk("rst_fd_insn", fd_insn, 32'd0);
    reset = 1'b0;
    #1 chk("flush_after_rst", 32'(flush), 32'd0);

    // Priming and sequential fetch.
    tick();
    chk("prime_fd_valid", 32'(fd_valid), 32'd0);
    chk("prime_imem_addr", 32'(imem_addr), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_fd_valid", 32'(fd_valid), 32'd1);
      chk("seq_fd_pc", 32'(fd_pc), 32'(i));
      chk("seq_fd_insn", fd_insn, 32'(i));
    end

    // Taken bne with negative offset: 10+1-3 = 8.
    ex_bne = 1; ex_neq = 1; ex_pc = 12'd10; ex_imm = 17'h1FFFD;
    #1 chk("bne_flush", 32'(flush), 32'd1);
    tick(); quiet();
    chk("bne_imem_addr", 32'(imem_addr), 32'd8);
    chk("bne_fd_valid", 32'(fd_valid), 32'd0);
    tick();
    chk("bne_bubble", 32'(fd_valid), 32'd0);
    tick();
    chk("bne_fd_pc", 32'(fd_pc), 32'd8);

    // Not-taken blt and not-taken bex.
    ex_blt = 1; ex_lt = 0; ex_pc = 12'd3; ex_imm = 17'd20;
    #1 chk("blt_nt_flush", 32'(flush), 32'd0);
    tick(); quiet();
    chk("blt_nt_addr", 32'(imem_addr), 32'd11);
    ex_bex = 1; ex_target = 27'd500;
    tick(); quiet();
    chk("bex_nt_addr", 32'(imem_addr), 32'd12);

    // Jump to 3, then stall with imem_addr at 5.
    ex_j = 1; ex_target = 27'd3;
    tick(); quiet();
    tick(); tick();
    chk("pre_stall_addr", 32'(imem_addr), 32'd5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", 32'(imem_addr), 32'd5);
      chk("stall_fd_pc", 32'(fd_pc), 32'd3);
    end
    ex_jr = 1; ex_rd_val = 32'd40;
    #1 chk("stall_jr_flush", 32'(flush), 32'd1);
    tick(); quiet();
    chk("stall_jr_addr", 32'(imem_addr), 32'd40);
    tick(); tick();
    chk("jr_fd_pc", 32'(fd_pc), 32'd40);

    // Stall then resume without redirect: no instruction may be lost.
    stall = 1;
    tick(); tick();
    stall = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("resume_fd_pc", 32'(fd_pc), 32'd44);
    chk("resume_addr", 32'(imem_addr), 32'd46);

    // jr outranks bex and j; upper rd_val bits ignored.
    ex_jr = 1; ex_j = 1; ex_bex = 1; ex_rstatus_nz = 1;
    ex_rd_val = 32'hFFFF_F0C8; ex_target = 27'd300;
    tick(); quiet();
    chk("jr_prio_addr", 32'(imem_addr), 32'd200);
    tick(); tick();
    chk("jr_prio_fd_pc", 32'(fd_pc), 32'd200);

    // jal: link and target truncated to PC_W.
    ex_jal = 1; ex_pc = 12'd7; ex_target = 27'h1234064;
    #1 chk("jal_link", 32'(link_pc), 32'd8);
    tick(); quiet();
    chk("jal_addr", 32'(imem_addr), 32'd100);

    // Branch target wraps below zero: 1+1-5 = 4093; pc then wraps past 4095.
    ex_bne = 1; ex_neq = 1; ex_pc = 12'd1; ex_imm = 17'h1FFFB;
    tick(); quiet();
    chk("wrap_target", 32'(imem_addr), 32'd4093);
    tick(); tick();
    chk("wrap_max", 32'(imem_addr), 32'd4095);
    tick();
    chk("wrap_zero", 32'(imem_addr), 32'd0);
    tick(); tick();
    chk("wrap_fd_pc", 32'(fd_pc), 32'd0);

    // Taken blt forward.
    ex_blt = 1; ex_lt = 1; ex_pc = 12'd100; ex_imm = 17'd50;
    tick(); quiet();
    chk("blt_addr", 32'(imem_addr), 32'd151);

    // Redirect while in SQUASH re-enters SQUASH at the new target.
    ex_j = 1; ex_target = 27'd60;
    tick();
    ex_target = 27'd70;
    tick(); quiet();
    chk("sq_redirect_addr", 32'(imem_addr), 32'd70);
    tick(); tick();
    chk("sq_redirect_fd_pc", 32'(fd_pc), 32'd70);

    // Reset in SQUASH overrides simultaneous stall and redirect.
    ex_j = 1; ex_target = 27'd80;
    tick(); quiet();
    reset = 1; stall = 1; ex_jr = 1; ex_rd_val = 32'd90;
    tick();
    chk("rst_sq_addr", 32'(imem_addr), 32'd0);
    chk("rst_sq_valid", 32'(fd_valid), 32'd0);
    reset = 0; quiet();

    // Redirect taken in PRIME.
    ex_j = 1; ex_target = 27'd20;
    tick(); quiet();
    chk("prime_redirect_addr", 32'(imem_addr), 32'd20);
    tick(); tick();
    chk("prime_redirect_fd_pc", 32'(fd_pc), 32'd20);
    for (int i = 0; i < 3; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 12, SHALL set the instruction-memory word-address width.
REQ-002 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-004 Port imem_addr, output, PC_W, SHALL be the word address to synchronous IMEM; data returns one cycle later.
REQ-005 Port imem_q, input, 32, SHALL be the IMEM read data for the previous cycle's imem_addr.
REQ-006 Port stall, input, 1, SHALL be the hazard request to hold fetch state.
REQ-007 Ports ex_j, ex_jal, ex_jr, ex_bne, ex_blt, ex_bex, inputs, 1 each, SHALL be the decoded control bits of the instruction in execute.
REQ-008 Ports ex_neq, ex_lt, ex_rstatus_nz, inputs, 1 each, SHALL be the execute compare results: rd!=rs, rd<rs, $rstatus!=0.
REQ-009 Ports ex_pc (PC_W), ex_target (27), ex_imm (17), ex_rd_val (32), inputs, SHALL be the execute PC, T field, N field and rd value.
REQ-010 Port fd_insn, output, 32, SHALL be the fetched instruction to decode.
REQ-011 Port fd_pc, output, PC_W, SHALL be the address of fd_insn.
REQ-012 Port fd_valid, output, 1, SHALL mark fd_insn as a real (non-bubble) instruction.
REQ-013 Port flush, output, 1, SHALL pulse for the cycle a redirect is taken, squashing decode/execute.
REQ-014 Port link_pc, output, PC_W, SHALL equal ex_pc+1 for the jal $r31 write.

Function
REQ-015 States SHALL be PRIME, RUN, SQUASH.
REQ-016 PRIME: entered on reset; fd_valid=0; next state RUN; pc advances to 1.
REQ-017 RUN: fd_insn<=imem_q, fd_pc<=pc of the preceding cycle, fd_valid<=1; pc<=pc+1 unless stalled or redirected.
REQ-018 Redirect taken SHALL be: ex_jr | ex_j | ex_jal | (ex_bex & ex_rstatus_nz) | (ex_bne & ex_neq) | (ex_blt & ex_lt).
REQ-019 Target priority SHALL be jr > bex > j/jal > bne > blt.
REQ-020 Targets: jr -> ex_rd_val[PC_W-1:0]; j/jal/bex -> ex_target[PC_W-1:0]; bne/blt -> ex_pc+1+sign-extended ex_imm, modulo 2^PC_W.
REQ-021 On redirect: flush=1 that cycle, pc<=target, fd_valid<=0, next state SQUASH.
REQ-022 SQUASH: discard imem_q (wrong path), fd_valid=0, pc<=pc+1, next state RUN.
REQ-023 stall without redirect SHALL hold pc, imem_addr, fd_insn, fd_pc, fd_valid and state unchanged.
REQ-024 Simultaneous stall and redirect: redirect SHALL win; stall ignored that cycle.
REQ-025 Redirect asserted in SQUASH or PRIME SHALL be taken identically (re-enter SQUASH).
REQ-026 pc SHALL wrap from 2^PC_W-1 to 0 with no flag.
REQ-027 imem_addr SHALL equal the pc register at all times (registered, no combinational path from ex_* inputs).
REQ-028 flush SHALL be combinational from the redirect condition; all other outputs registered.

Reset
REQ-029 On reset: pc=0, state=PRIME, fd_insn=0, fd_pc=0, fd_valid=0, imem_addr=0.
REQ-030 Reset asserted mid-operation SHALL override stall and redirect in the same cycle.
REQ-031 flush and link_pc SHALL be don't-care while reset is high; flush SHALL be 0 in the first cycle after reset with quiet ex_* inputs.

Structure
REQ-032 Shared package SHALL hold opcode constants (J=00001, BNE=00010, JAL=00011, JR=00100, BLT=00110, BEX=10110), field widths (27, 17) and the state encoding.
REQ-033 One sub-module branch_target SHALL compute redirect-taken and target combinationally per REQ-018..020.

Verification
REQ-034 Reset, IMEM returns word=addr: fd_valid=0 first cycle, then fd_pc=0,1,2 with fd_insn=0,1,2.
REQ-035 ex_bne=1, ex_neq=1, ex_pc=10, ex_imm=-3: flush=1, imem_addr=8 next cycle, one bubble, then fd_pc=8.
REQ-036 ex_blt=1, ex_lt=0: no flush, sequential fetch continues.
REQ-037 stall=1 for 3 cycles at pc=5: imem_addr/fd_pc frozen; stall+ex_jr (rd_val=40) same cycle -> fetch resumes at 40.
REQ-038 ex_jal, ex_pc=7, ex_target=100: link_pc=8, next fetch 100; pc at 4095 increments to 0.
REQ-039 Reset asserted during SQUASH: next cycle state PRIME, imem_addr=0, fd_valid=0.
